// File: rtl/wsp_scan_sequencer.sv
// IEEE 1500 WSP sequencer: loads a WIR instruction, then optionally runs a
// capture/shift/update scan of a data register. Optional WSP_HOLD_EN adds a shift-stall input `hold`.
module wsp_scan_sequencer #(
    parameter int WIR_WIDTH = 12,
    parameter int DR_WIDTH  = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 WRCK,
    input  logic                 WRSTN,
    input  logic                 start,
    input  logic [WIR_WIDTH-1:0] wir_code,
    input  logic [CNT_WIDTH-1:0] dr_len,
    input  logic [DR_WIDTH-1:0]  dr_data_in,
    input  logic                 WSO,
`ifdef WSP_HOLD_EN
    input  logic                 hold,
`endif
    output logic                 SelectWIR,
    output logic                 CaptureWR,
    output logic                 ShiftWR,
    output logic                 UpdateWR,
    output logic                 WSI,
    output logic                 busy,
    output logic                 done,
    output logic [DR_WIDTH-1:0]  dr_data_out
);

    localparam int WIR_IW = (WIR_WIDTH > 1) ? $clog2(WIR_WIDTH) : 1;
    localparam int DR_IW  = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
    localparam logic [CNT_WIDTH-1:0] WIR_LAST = CNT_WIDTH'(WIR_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] DR_MAX   = CNT_WIDTH'(DR_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WIR_SHIFT  = 3'd1,
        S_WIR_UPDATE = 3'd2,
        S_DR_CAPTURE = 3'd3,
        S_DR_SHIFT   = 3'd4,
        S_DR_UPDATE  = 3'd5,
        S_DONE       = 3'd6
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [CNT_WIDTH-1:0]  w_cnt_nxt;
    logic [CNT_WIDTH-1:0]  w_cnt_inc;
    logic [WIR_WIDTH-1:0]  r_wir;
    logic [DR_WIDTH-1:0]   r_din;
    logic [CNT_WIDTH-1:0]  r_len;
    logic [CNT_WIDTH-1:0]  w_len_clamp;
    logic [DR_WIDTH-1:0]   r_dout;

    logic r_sel, r_cap, r_shift, r_upd, r_wsi, r_busy, r_done;
    logic w_sel_nxt, w_cap_nxt, w_shift_nxt, w_upd_nxt, w_wsi_nxt, w_busy_nxt, w_done_nxt;
    logic w_latch, w_dout_clr, w_dout_smp;
    logic w_hold;
    logic w_wir_bit_cur, w_wir_bit_inc, w_din_bit_cur, w_din_bit_inc;

`ifdef WSP_HOLD_EN
    assign w_hold = hold;
`else
    assign w_hold = 1'b0;
`endif

    assign w_cnt_inc     = r_cnt + 1'b1;
    assign w_len_clamp   = (dr_len > DR_MAX) ? DR_MAX : dr_len;
    assign w_wir_bit_cur = r_wir[r_cnt[WIR_IW-1:0]];
    assign w_wir_bit_inc = r_wir[w_cnt_inc[WIR_IW-1:0]];
    assign w_din_bit_cur = r_din[r_cnt[DR_IW-1:0]];
    assign w_din_bit_inc = r_din[w_cnt_inc[DR_IW-1:0]];

    always_ff @(posedge WRCK or negedge WRSTN) begin
        if (!WRSTN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Outputs are decoded for the next state and registered, so each strobe
    // is glitch-free and lines up with the state it belongs to. A cycle with
    // ShiftWR high is a real shift; a held cycle re-presents the same bit.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        w_dout_clr  = 1'b0;
        w_dout_smp  = 1'b0;
        w_sel_nxt   = 1'b0;
        w_cap_nxt   = 1'b0;
        w_shift_nxt = 1'b0;
        w_upd_nxt   = 1'b0;
        w_wsi_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_WIR_SHIFT;
                    w_cnt_nxt   = '0;
                    w_sel_nxt   = 1'b1;
                    w_shift_nxt = 1'b1;
                    w_wsi_nxt   = wir_code[0];
                    w_busy_nxt  = 1'b1;
                end
            end
            S_WIR_SHIFT: begin
                w_sel_nxt  = 1'b1;
                w_busy_nxt = 1'b1;
                if (r_shift && (r_cnt == WIR_LAST)) begin
                    w_state_nxt = S_WIR_UPDATE;
                    w_upd_nxt   = 1'b1;
                end else if (r_shift) begin
                    w_cnt_nxt   = w_cnt_inc;
                    w_shift_nxt = !w_hold;
                    w_wsi_nxt   = w_wir_bit_inc;
                end else begin
                    w_shift_nxt = !w_hold;
                    w_wsi_nxt   = w_wir_bit_cur;
                end
            end
            S_WIR_UPDATE: begin
                if (r_len != '0) begin
                    w_state_nxt = S_DR_CAPTURE;
                    w_cap_nxt   = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_dout_clr  = 1'b1;
                end else begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                end
            end
            S_DR_CAPTURE: begin
                w_state_nxt = S_DR_SHIFT;
                w_cnt_nxt   = '0;
                w_shift_nxt = 1'b1;
                w_wsi_nxt   = r_din[0];
                w_busy_nxt  = 1'b1;
            end
            S_DR_SHIFT: begin
                w_busy_nxt = 1'b1;
                w_dout_smp = r_shift;
                if (r_shift && (r_cnt == r_len - 1'b1)) begin
                    w_state_nxt = S_DR_UPDATE;
                    w_upd_nxt   = 1'b1;
                end else if (r_shift) begin
                    w_cnt_nxt   = w_cnt_inc;
                    w_shift_nxt = !w_hold;
                    w_wsi_nxt   = w_din_bit_inc;
                end else begin
                    w_shift_nxt = !w_hold;
                    w_wsi_nxt   = w_din_bit_cur;
                end
            end
            S_DR_UPDATE: begin
                w_state_nxt = S_DONE;
                w_done_nxt  = 1'b1;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge WRCK or negedge WRSTN) begin
        if (!WRSTN) begin
            r_cnt   <= '0;
            r_wir   <= '0;
            r_din   <= '0;
            r_len   <= '0;
            r_dout  <= '0;
            r_sel   <= 1'b0;
            r_cap   <= 1'b0;
            r_shift <= 1'b0;
            r_upd   <= 1'b0;
            r_wsi   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel_nxt;
            r_cap   <= w_cap_nxt;
            r_shift <= w_shift_nxt;
            r_upd   <= w_upd_nxt;
            r_wsi   <= w_wsi_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            if (w_latch) begin
                r_wir <= wir_code;
                r_din <= dr_data_in;
                r_len <= w_len_clamp;
            end
            if (w_dout_clr) begin
                r_dout <= '0;
            end else if (w_dout_smp) begin
                r_dout[r_cnt[DR_IW-1:0]] <= WSO;
            end
        end
    end

    assign SelectWIR   = r_sel;
    assign CaptureWR   = r_cap;
    assign ShiftWR     = r_shift;
    assign UpdateWR    = r_upd;
    assign WSI         = r_wsi;
    assign busy        = r_busy;
    assign done        = r_done;
    assign dr_data_out = r_dout;

endmodule

// File: tb/tb_wsp_scan_sequencer.sv
// Bench for wsp_scan_sequencer: cycle-by-cycle comparison of the WSP strobes
// against a phase-list reference built from the sequence rules.
module tb_wsp_scan_sequencer;

    localparam int WIR_W = 12;
    localparam int DR_W  = 16;
    localparam int CNT_W = 8;

    logic             WRCK = 1'b0;
    logic             WRSTN;
    logic             start;
    logic [WIR_W-1:0] wir_code;
    logic [CNT_W-1:0] dr_len;
    logic [DR_W-1:0]  dr_data_in;
    logic             WSO;
    logic             hold;
    logic             SelectWIR, CaptureWR, ShiftWR, UpdateWR, WSI, busy, done;
    logic [DR_W-1:0]  dr_data_out;

    wsp_scan_sequencer #(.WIR_WIDTH(WIR_W), .DR_WIDTH(DR_W), .CNT_WIDTH(CNT_W)) dut (
        .WRCK        (WRCK),
        .WRSTN       (WRSTN),
        .start       (start),
        .wir_code    (wir_code),
        .dr_len      (dr_len),
        .dr_data_in  (dr_data_in),
        .WSO         (WSO),
`ifdef WSP_HOLD_EN
        .hold        (hold),
`endif
        .SelectWIR   (SelectWIR),
        .CaptureWR   (CaptureWR),
        .ShiftWR     (ShiftWR),
        .UpdateWR    (UpdateWR),
        .WSI         (WSI),
        .busy        (busy),
        .done        (done),
        .dr_data_out (dr_data_out)
    );

    always #5 WRCK = ~WRCK;

    // WSO source: 0 = random per cycle, 1 = tied high, 2 = 1-bit bypass loop
    int   wso_mode = 0;
    logic wso_drv  = 1'b0;
    logic byp;
    always @(posedge WRCK or negedge WRSTN) begin
        if (!WRSTN) byp <= 1'b0;
        else        byp <= WSI;
    end
    assign WSO = (wso_mode == 2) ? byp : wso_drv;

    int              n_cmp = 0;
    int              n_err = 0;
    int              seq_id = 0;
    logic [6:0]      exp_q[$];
    int              bit_q[$];
    logic [DR_W-1:0] exp_dout = '0;

    task automatic cyc();
        @(posedge WRCK);
        #1;
    endtask

    function automatic logic [6:0] obs_vec();
        return {SelectWIR, CaptureWR, ShiftWR, UpdateWR, WSI, busy, done};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Expected per-cycle {SelectWIR,CaptureWR,ShiftWR,UpdateWR,WSI,busy,done}
    // from the first WIR shift cycle through DONE; bit_q marks DR shift bits.
    task automatic build(input logic [WIR_W-1:0] wir, input int L,
                         input logic [DR_W-1:0] din, input int hold_at);
        exp_q.delete();
        bit_q.delete();
        for (int i = 0; i < WIR_W; i++) begin
            exp_q.push_back({1'b1, 1'b0, 1'b1, 1'b0, wir[i], 1'b1, 1'b0});
            bit_q.push_back(-1);
            if (i == hold_at) begin
                for (int j = 0; j < 3; j++) begin
                    exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, wir[i+1], 1'b1, 1'b0});
                    bit_q.push_back(-1);
                end
            end
        end
        exp_q.push_back(7'b1001010); bit_q.push_back(-1);
        if (L > 0) begin
            exp_q.push_back(7'b0100010); bit_q.push_back(-1);
            for (int i = 0; i < L; i++) begin
                exp_q.push_back({1'b0, 1'b0, 1'b1, 1'b0, din[i], 1'b1, 1'b0});
                bit_q.push_back(i);
            end
            exp_q.push_back(7'b0001010); bit_q.push_back(-1);
        end
        exp_q.push_back(7'b0000001); bit_q.push_back(-1);
    endtask

    // Called in an IDLE cycle; raises start and walks the expected trace.
    task automatic run_seq(input logic [WIR_W-1:0] wir, input int len,
                           input logic [DR_W-1:0] din, input int mode,
                           input int rnd_start, input int keep_start,
                           input int hold_at, input int abort_at);
        int              L;
        logic [DR_W-1:0] nd;
        logic            w;
        L = (len > DR_W) ? DR_W : len;
        build(wir, L, din, hold_at);
        seq_id++;
        wso_mode   = mode;
        wso_drv    = (mode == 1);
        wir_code   = wir;
        dr_len     = CNT_W'(len);
        dr_data_in = din;
        start      = 1'b1;
        cyc();
        nd = (L > 0) ? '0 : exp_dout;
        for (int k = 0; k < exp_q.size(); k++) begin
            chk($sformatf("seq%0d_cyc%0d", seq_id, k), 32'(obs_vec()), 32'(exp_q[k]));
            if (k == abort_at) begin
                WRSTN = 1'b0;
                #2;
                chk("abort_outputs_zero", 32'({obs_vec(), dr_data_out}), 32'd0);
                WRSTN    = 1'b1;
                exp_dout = '0;
                start    = 1'b0;
                hold     = 1'b0;
                cyc();
                chk("abort_idle", 32'(obs_vec()), 32'd0);
                return;
            end
            if (mode == 0) wso_drv = 1'($urandom_range(0, 1));
            w = (mode == 2) ? byp : ((mode == 1) ? 1'b1 : wso_drv);
            if (bit_q[k] >= 0) nd[bit_q[k]] = w;
            start      = keep_start ? 1'b1 : (rnd_start ? 1'($urandom_range(0, 1)) : 1'b0);
            wir_code   = WIR_W'($urandom);
            dr_len     = CNT_W'($urandom_range(0, 30));
            dr_data_in = DR_W'($urandom);
            hold       = (hold_at >= 0 && k >= hold_at && k < hold_at + 3);
            cyc();
        end
        exp_dout = nd;
        chk($sformatf("seq%0d_idle", seq_id), 32'(obs_vec()), 32'd0);
        chk($sformatf("seq%0d_dout", seq_id), 32'(dr_data_out), 32'(exp_dout));
        start = keep_start ? 1'b1 : 1'b0;
        hold  = 1'b0;
    endtask

    initial begin
        WRSTN      = 1'b0;
        start      = 1'b0;
        hold       = 1'b0;
        wir_code   = '0;
        dr_len     = '0;
        dr_data_in = '0;
        repeat (3) @(posedge WRCK);
        #1;
        chk("reset_outputs", 32'({obs_vec(), dr_data_out}), 32'd0);
        WRSTN = 1'b1;
        cyc();
        chk("post_reset_idle", 32'(obs_vec()), 32'd0);

        // Instruction-only load with the reference instruction
        run_seq(12'b101100010100, 0, '0, 0, 0, 0, -1, -1);

        // Bypass loop: A5 comes back delayed one bit
        run_seq(WIR_W'($urandom), 8, 16'h00A5, 2, 0, 0, -1, -1);
        chk("bypass_dout", 32'(dr_data_out), 32'h0000_004A);

        // Over-length request clamps to DR_W shift cycles
        run_seq(WIR_W'($urandom), 20, DR_W'($urandom), 1, 0, 0, -1, -1);
        chk("clamp_dout", 32'(dr_data_out), 32'h0000_FFFF);

        // Reset during DR shift cycle 3, then a normal full sequence
        run_seq(WIR_W'($urandom), 10, DR_W'($urandom), 0, 0, 0, -1, WIR_W + 5);
        run_seq(WIR_W'($urandom), 6, DR_W'($urandom), 0, 0, 0, -1, -1);

        // Start held high: back-to-back sequences with one IDLE cycle between
        run_seq(WIR_W'($urandom), 0, DR_W'($urandom), 0, 0, 1, -1, -1);
        run_seq(WIR_W'($urandom), 5, DR_W'($urandom), 0, 0, 1, -1, -1);
        run_seq(WIR_W'($urandom), 3, DR_W'($urandom), 0, 0, 0, -1, -1);

`ifdef WSP_HOLD_EN
        run_seq(WIR_W'($urandom), 4, DR_W'($urandom), 0, 0, 0, 4, -1);
`endif

        // Random sequences with stray start pulses while busy
        for (int n = 0; n < 10; n++) begin
            run_seq(WIR_W'($urandom), int'($urandom_range(0, 20)), DR_W'($urandom),
                    int'($urandom_range(0, 2)), 1, 0, -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
